// File: rtl/hazard_scoreboard_ysyx_23060136.sv
// Forward/hazard unit: MEM/WB -> EXU bypass, WB -> ID-EX bypass, registered load-use bubble FSM.
// Optional STALL_PERF_EN adds saturating load-use and stall performance counters.
module hazard_scoreboard_ysyx_23060136 #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5
`ifdef STALL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifu_valid,
    input  logic            mem_rvalid,
    input  logic            mem_wready,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic            ex_valid,
    input  logic [RAW-1:0]  ex_rs1,
    input  logic [RAW-1:0]  ex_rs2,
    input  logic            mem_valid,
    input  logic            mem_wgpr,
    input  logic            mem_load,
    input  logic [RAW-1:0]  mem_rd,
    input  logic [XLEN-1:0] mem_alu_out,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            wb_valid,
    input  logic            wb_wgpr,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            stall_me,
    output logic            stall_wb,
    output logic            flush_ex,
    output logic            fwd_ex_rs1_en,
    output logic [XLEN-1:0] fwd_ex_rs1_data,
    output logic            fwd_ex_rs2_en,
    output logic [XLEN-1:0] fwd_ex_rs2_data,
    output logic            fwd_seg_rs1_en,
    output logic [XLEN-1:0] fwd_seg_rs1_data,
    output logic            fwd_seg_rs2_en,
    output logic [XLEN-1:0] fwd_seg_rs2_data
`ifdef STALL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_lu_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    typedef enum logic [0:0] {IDLE, LU_HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] hold_data;
    logic            hold_m1;
    logic            hold_m2;

    // A producer matches only if it is real, writes a GPR, targets src, and src is not x0.
    function automatic logic hit(input logic v, input logic w,
                                 input logic [RAW-1:0] rd, input logic [RAW-1:0] src);
        return v & w & (rd == src) & (rd != '0);
    endfunction

    logic mem_ok;
    logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic lu, lu_start;

    assign mem_ok   = ifu_valid & mem_rvalid & mem_wready;
    assign mem_hit1 = hit(mem_valid, mem_wgpr, mem_rd, ex_rs1);
    assign mem_hit2 = hit(mem_valid, mem_wgpr, mem_rd, ex_rs2);
    assign wb_hit1  = hit(wb_valid, wb_wgpr, wb_rd, ex_rs1);
    assign wb_hit2  = hit(wb_valid, wb_wgpr, wb_rd, ex_rs2);
    assign lu       = ex_valid & mem_load & (mem_hit1 | mem_hit2);
    assign lu_start = (state == IDLE) & lu & mem_ok;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stall_if = ~mem_ok;
        stall_id = ~mem_ok;
        stall_ex = ~mem_ok;
        stall_me = ~mem_ok;
        stall_wb = ~mem_ok;
        flush_ex = 1'b0;
        if (lu_start) begin
            // Freeze the consumer in EX and push a bubble into MEM while the load retires.
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
            stall_me = 1'b0;
            stall_wb = 1'b0;
            flush_ex = 1'b1;
        end
    end

    always_comb begin
        fwd_ex_rs1_en   = 1'b0;
        fwd_ex_rs1_data = '0;
        if ((state == LU_HOLD) && hold_m1) begin
            fwd_ex_rs1_en   = 1'b1;
            fwd_ex_rs1_data = hold_data;
        end else if (mem_hit1 && !mem_load) begin
            fwd_ex_rs1_en   = 1'b1;
            fwd_ex_rs1_data = mem_alu_out;
        end else if (wb_hit1) begin
            fwd_ex_rs1_en   = 1'b1;
            fwd_ex_rs1_data = wb_data;
        end
    end

    always_comb begin
        fwd_ex_rs2_en   = 1'b0;
        fwd_ex_rs2_data = '0;
        if ((state == LU_HOLD) && hold_m2) begin
            fwd_ex_rs2_en   = 1'b1;
            fwd_ex_rs2_data = hold_data;
        end else if (mem_hit2 && !mem_load) begin
            fwd_ex_rs2_en   = 1'b1;
            fwd_ex_rs2_data = mem_alu_out;
        end else if (wb_hit2) begin
            fwd_ex_rs2_en   = 1'b1;
            fwd_ex_rs2_data = wb_data;
        end
    end

    assign fwd_seg_rs1_en   = hit(wb_valid, wb_wgpr, wb_rd, id_rs1);
    assign fwd_seg_rs2_en   = hit(wb_valid, wb_wgpr, wb_rd, id_rs2);
    assign fwd_seg_rs1_data = fwd_seg_rs1_en ? wb_data : '0;
    assign fwd_seg_rs2_data = fwd_seg_rs2_en ? wb_data : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: hold_data is a plain register (not a memory) so it is reset to a known 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_m1   <= 1'b0;
            hold_m2   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu_start) begin
                        hold_data <= mem_rdata;
                        hold_m1   <= mem_hit1;
                        hold_m2   <= mem_hit2;
                        state     <= LU_HOLD;
                    end
                end
                LU_HOLD: begin
                    if (mem_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STALL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (lu_start && (perf_lu_cnt != '1))
                perf_lu_cnt <= perf_lu_cnt + CNT_W'(1);
            if (!mem_ok && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
